// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI4 read arbiter: merges NPORT requesters onto one AR/R master port,
// one burst outstanding at a time, with ID tagging and burst-length checking.
module axi_rd_arbiter #(
   parameter int                NPORT      = 2,
   parameter int                ADDR_W     = 64,
   parameter int                DATA_W     = 64,
   parameter int                ID_W       = 4,
   parameter logic [NPORT-1:0]  INSTR_MASK = NPORT'('b01)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NPORT-1:0]        req_valid,
   output logic [NPORT-1:0]        req_ready,
   input  logic [NPORT*ADDR_W-1:0] req_addr,
   input  logic [NPORT*8-1:0]      req_len,
   input  logic [NPORT*3-1:0]      req_size,
   output logic [NPORT-1:0]        rsp_valid,
   input  logic [NPORT-1:0]        rsp_ready,
   output logic [DATA_W-1:0]       rsp_data,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_last,
   output logic [ID_W-1:0]         ARID,
   output logic [ADDR_W-1:0]       ARADDR,
   output logic [7:0]              ARLEN,
   output logic [2:0]              ARSIZE,
   output logic [1:0]              ARBURST,
   output logic [2:0]              ARPORT,
   output logic                    ARVALID,
   output logic                    ARLOCK,
   output logic [3:0]              ARCACHE,
   output logic [3:0]              ARQOS,
   output logic [3:0]              ARREGION,
   input  logic                    ARREADY,
   input  logic [ID_W-1:0]         RID,
   input  logic [DATA_W-1:0]       RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RLAST,
   input  logic                    RVALID,
   output logic                    RREADY,
   output logic [1:0]              o_dbg_state
);

   localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    r_gnt;
   logic [IDX_W-1:0]    w_gnt;
   logic [IDX_W-1:0]    w_idx;
   logic [IDX_W-1:0]    w_ptr_nxt;
   logic                w_gnt_vld;
   logic [7:0]          r_beat_cnt;
   logic                w_beat_last;
   logic                w_r_hs;
   logic                w_burst_end;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [7:0]          w_sel_len;
   logic [2:0]          w_sel_size;
   logic                w_sel_instr;
   logic [ID_W-1:0]     r_arid;
   logic [ADDR_W-1:0]   r_araddr;
   logic [7:0]          r_arlen;
   logic [2:0]          r_arsize;
   logic [1:0]          r_arburst;
   logic [2:0]          r_arport;

   // First requester at or after r_rr_ptr, wrapping past NPORT-1 to 0.
   always_comb begin : arbiter
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_idx     = '0;
      for (int k = 0; k < NPORT; k++) begin
         w_idx = IDX_W'((int'(r_rr_ptr) + k) % NPORT);
         if (!w_gnt_vld && req_valid[w_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_idx;
         end
      end
   end

   always_comb begin : req_mux
      w_sel_addr  = '0;
      w_sel_len   = '0;
      w_sel_size  = '0;
      w_sel_instr = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
         if (w_gnt == IDX_W'(i)) begin
            w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_len   = req_len[i*8 +: 8];
            w_sel_size  = req_size[i*3 +: 3];
            w_sel_instr = INSTR_MASK[i];
         end
      end
   end

   // A burst ends on whichever comes first: slave RLAST or the ARLEN-th beat.
   assign w_beat_last = (r_beat_cnt == r_arlen);
   assign w_r_hs      = RVALID && RREADY;
   assign w_burst_end = w_r_hs && (RLAST || w_beat_last);
   assign w_ptr_nxt   = (r_gnt == IDX_W'(NPORT - 1)) ? '0 : r_gnt + IDX_W'(1);

   always_ff @(posedge clk or posedge rst) begin : state_reg
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin : next_state
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_gnt_vld)   w_state_nxt = S_ADDR;
         S_ADDR:  if (ARREADY)     w_state_nxt = S_DATA;
         S_DATA:  if (w_burst_end) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin : datapath
      if (rst) begin
         r_rr_ptr   <= '0;
         r_gnt      <= '0;
         r_beat_cnt <= '0;
         r_arid     <= '0;
         r_araddr   <= '0;
         r_arlen    <= '0;
         r_arsize   <= '0;
         r_arburst  <= '0;
         r_arport   <= '0;
      end else begin
         if (r_state == S_IDLE && w_gnt_vld) begin
            r_gnt      <= w_gnt;
            r_beat_cnt <= '0;
            r_arid     <= ID_W'(w_gnt);
            r_araddr   <= w_sel_addr;
            r_arlen    <= w_sel_len;
            r_arsize   <= w_sel_size;
            r_arburst  <= 2'b01;
            r_arport   <= {w_sel_instr, 2'b00};
         end
         if (r_state == S_DATA && w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
         end
         if (r_state == S_DATA && w_burst_end) begin
            r_rr_ptr <= w_ptr_nxt;
         end
      end
   end

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // a valid source holds its payload stable until that edge.
   always_comb begin : outputs
      req_ready = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      rsp_resp  = '0;
      rsp_last  = 1'b0;
      RREADY    = 1'b0;
      ARVALID   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_gnt_vld) req_ready[w_gnt] = 1'b1;
         end
         S_ADDR: begin
            ARVALID = 1'b1;
         end
         S_DATA: begin
            RREADY           = rsp_ready[r_gnt];
            rsp_valid[r_gnt] = RVALID;
            rsp_data         = RDATA;
            rsp_last         = w_beat_last;
            rsp_resp         = ((RID != ID_W'(r_gnt)) || (RLAST != w_beat_last)) ? 2'b10 : RRESP;
         end
         default: ;
      endcase
   end

   assign ARID        = r_arid;
   assign ARADDR      = r_araddr;
   assign ARLEN       = r_arlen;
   assign ARSIZE      = r_arsize;
   assign ARBURST     = r_arburst;
   assign ARPORT      = r_arport;
   assign ARLOCK      = 1'b0;
   assign ARCACHE     = 4'd0;
   assign ARQOS       = 4'd0;
   assign ARREGION    = 4'd0;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a 2-port instance for the main scenarios and
// a 4-port instance for wide round-robin and instruction-mask tagging.
module tb_axi_rd_arbiter;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   // 2-port instance
   logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [127:0] req_addr;
   logic [15:0]  req_len;
   logic [5:0]   req_size;
   logic [63:0]  rsp_data, araddr, rdata;
   logic [1:0]   rsp_resp, arburst, rresp, dbg_state;
   logic         rsp_last, arvalid, arlock, arready, rlast, rvalid, rready;
   logic [3:0]   arid, arcache, arqos, arregion, rid;
   logic [7:0]   arlen;
   logic [2:0]   arsize, arport;

   // 4-port instance
   logic [3:0]   req_valid_4, req_ready_4, rsp_valid_4, rsp_ready_4;
   logic [255:0] req_addr_4;
   logic [31:0]  req_len_4;
   logic [11:0]  req_size_4;
   logic [63:0]  rsp_data_4, araddr_4, rdata_4;
   logic [1:0]   rsp_resp_4, arburst_4, rresp_4, dbg_state_4;
   logic         rsp_last_4, arvalid_4, arlock_4, arready_4, rlast_4, rvalid_4, rready_4;
   logic [3:0]   arid_4, arcache_4, arqos_4, arregion_4, rid_4;
   logic [7:0]   arlen_4;
   logic [2:0]   arsize_4, arport_4;

   axi_rd_arbiter #(.NPORT(2), .ADDR_W(64), .DATA_W(64), .ID_W(4), .INSTR_MASK(2'b01)) u_dut2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_len(req_len), .req_size(req_size),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_resp(rsp_resp), .rsp_last(rsp_last),
      .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize), .ARBURST(arburst),
      .ARPORT(arport), .ARVALID(arvalid), .ARLOCK(arlock), .ARCACHE(arcache),
      .ARQOS(arqos), .ARREGION(arregion), .ARREADY(arready),
      .RID(rid), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid),
      .RREADY(rready), .o_dbg_state(dbg_state)
   );

   axi_rd_arbiter #(.NPORT(4), .ADDR_W(64), .DATA_W(64), .ID_W(4), .INSTR_MASK(4'b0101)) u_dut4 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_4), .req_ready(req_ready_4), .req_addr(req_addr_4),
      .req_len(req_len_4), .req_size(req_size_4),
      .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4), .rsp_data(rsp_data_4),
      .rsp_resp(rsp_resp_4), .rsp_last(rsp_last_4),
      .ARID(arid_4), .ARADDR(araddr_4), .ARLEN(arlen_4), .ARSIZE(arsize_4), .ARBURST(arburst_4),
      .ARPORT(arport_4), .ARVALID(arvalid_4), .ARLOCK(arlock_4), .ARCACHE(arcache_4),
      .ARQOS(arqos_4), .ARREGION(arregion_4), .ARREADY(arready_4),
      .RID(rid_4), .RDATA(rdata_4), .RRESP(rresp_4), .RLAST(rlast_4), .RVALID(rvalid_4),
      .RREADY(rready_4), .o_dbg_state(dbg_state_4)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_r(input logic v, input logic [3:0] id, input logic [63:0] d,
                        input logic l, input logic [1:0] r);
      rvalid = v; rid = id; rdata = d; rlast = l; rresp = r;
   endtask

   task automatic set_r4(input logic v, input logic [3:0] id, input logic [63:0] d);
      rvalid_4 = v; rid_4 = id; rdata_4 = d; rlast_4 = 1'b1; rresp_4 = 2'b00;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int         gnt2_t[4]  = '{0, 1, 0, 1};
      logic [2:0] ap2_t[4]   = '{3'b100, 3'b000, 3'b100, 3'b000};
      int         gnt4_t[5]  = '{0, 1, 2, 3, 0};
      logic [2:0] ap4_t[5]   = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100};
      bit         rv_t[8]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      bit         rr_t[8]    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      int         b;
      int         nbeats;

      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      req_valid = '0; req_addr = '0; req_len = '0; req_size = '0; rsp_ready = '0;
      arready = 1'b0; set_r(1'b0, 4'd0, 64'd0, 1'b0, 2'b00);
      req_valid_4 = '0; req_addr_4 = '0; req_len_4 = '0; req_size_4 = '0; rsp_ready_4 = '0;
      arready_4 = 1'b0; set_r4(1'b0, 4'd0, 64'd0);

      // Reset values
      repeat (2) cyc();
      chk("rst_state", dbg_state, 2'd0);
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_araddr", araddr, 64'd0);
      chk("rst_arid", arid, 4'd0);
      chk("rst_rready", rready, 1'b0);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("ar_tied", {arlock, arcache, arqos, arregion}, 13'd0);
      rst = 1'b0;

      // 1: single 1-beat read from port 1, zero-wait slave
      req_valid = 2'b10;
      req_addr[64 +: 64] = 64'h8000_0010;
      req_len[8 +: 8] = 8'd0;
      req_size[3 +: 3] = 3'd3;
      arready = 1'b1;
      settle();
      chk("t1_req_ready", req_ready, 2'b10);
      cyc();
      req_valid = 2'b00;
      set_r(1'b1, 4'd1, 64'hCAFE_0001, 1'b1, 2'b00);
      rsp_ready = 2'b10;
      settle();
      chk("t1_state_addr", dbg_state, 2'd1);
      chk("t1_arvalid", arvalid, 1'b1);
      chk("t1_arid", arid, 4'd1);
      chk("t1_arport", arport, 3'b000);
      chk("t1_arburst", arburst, 2'b01);
      chk("t1_araddr", araddr, 64'h8000_0010);
      chk("t1_arlen", arlen, 8'd0);
      chk("t1_arsize", arsize, 3'd3);
      chk("t1_rready_addr", rready, 1'b0);
      chk("t1_rsp_valid_addr", rsp_valid, 2'b00);
      chk("t1_rsp_data_addr", rsp_data, 64'd0);
      chk("t1_req_ready_addr", req_ready, 2'b00);
      cyc();
      settle();
      chk("t1_arvalid_data", arvalid, 1'b0);
      chk("t1_rsp_valid", rsp_valid, 2'b10);
      chk("t1_rsp_data", rsp_data, 64'hCAFE_0001);
      chk("t1_rsp_last", rsp_last, 1'b1);
      chk("t1_rsp_resp", rsp_resp, 2'b00);
      chk("t1_rready", rready, 1'b1);
      cyc();
      set_r(1'b0, 4'd0, 64'd0, 1'b0, 2'b00);
      settle();
      chk("t1_state_idle", dbg_state, 2'd0);
      chk("t1_rsp_valid_idle", rsp_valid, 2'b00);

      // 2: both ports requesting continuously, grants alternate
      req_addr[0 +: 64] = 64'h100;
      req_addr[64 +: 64] = 64'h200;
      req_len = '0;
      rsp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         req_valid = 2'b11;
         settle();
         chk("t2_req_ready", req_ready, 2'b01 << gnt2_t[i]);
         cyc();
         set_r(1'b1, 4'(gnt2_t[i]), 64'h2000 + 64'(i), 1'b1, 2'b00);
         settle();
         chk("t2_arid", arid, 4'(gnt2_t[i]));
         chk("t2_arport", arport, ap2_t[i]);
         chk("t2_req_ready_busy", req_ready, 2'b00);
         cyc();
         settle();
         chk("t2_rsp_valid", rsp_valid, 2'b01 << gnt2_t[i]);
         chk("t2_rsp_data", rsp_data, 64'h2000 + 64'(i));
         cyc();
         set_r(1'b0, 4'd0, 64'd0, 1'b0, 2'b00);
      end

      // 3: port 0 len 3 with ARREADY held low, RVALID gaps and rsp_ready stalls
      req_valid = 2'b01;
      req_addr[0 +: 64] = 64'h1000;
      req_len[0 +: 8] = 8'd3;
      arready = 1'b0;
      rsp_ready = 2'b00;
      settle();
      chk("t3_req_ready", req_ready, 2'b01);
      cyc();
      req_valid = 2'b00;
      req_addr[0 +: 64] = 64'hDEAD;
      req_len[0 +: 8] = 8'd7;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("t3_arvalid_hold", arvalid, 1'b1);
         chk("t3_araddr_hold", araddr, 64'h1000);
         chk("t3_arlen_hold", arlen, 8'd3);
         cyc();
      end
      arready = 1'b1;
      cyc();
      arready = 1'b0;
      b = 0;
      nbeats = 0;
      for (int k = 0; k < 8; k++) begin
         set_r(rv_t[k], 4'd0, 64'hD0 + 64'(b), (b == 3), 2'b00);
         rsp_ready = {1'b0, rr_t[k]};
         settle();
         chk("t3_rsp_valid", rsp_valid, {1'b0, rv_t[k]});
         chk("t3_rsp_data", rsp_data, 64'hD0 + 64'(b));
         chk("t3_rsp_last", rsp_last, (b == 3));
         chk("t3_rsp_resp", rsp_resp, 2'b00);
         if (rsp_valid[0] && rsp_ready[0]) nbeats++;
         if (rv_t[k] && rr_t[k]) b++;
         cyc();
      end
      set_r(1'b0, 4'd0, 64'd0, 1'b0, 2'b00);
      settle();
      chk("t3_beats", nbeats, 4);
      chk("t3_state_idle", dbg_state, 2'd0);

      // 4a: wrong RID on the granted port
      req_valid = 2'b01;
      req_addr[0 +: 64] = 64'h3000;
      req_len[0 +: 8] = 8'd0;
      arready = 1'b1;
      rsp_ready = 2'b01;
      settle();
      chk("t4a_req_ready", req_ready, 2'b01);
      cyc();
      req_valid = 2'b00;
      set_r(1'b1, 4'd2, 64'h44, 1'b1, 2'b00);
      cyc();
      settle();
      chk("t4a_rsp_valid", rsp_valid, 2'b01);
      chk("t4a_rsp_resp", rsp_resp, 2'b10);
      chk("t4a_rsp_last", rsp_last, 1'b1);
      cyc();
      set_r(1'b0, 4'd0, 64'd0, 1'b0, 2'b00);
      settle();
      chk("t4a_state_idle", dbg_state, 2'd0);

      // 4b: early RLAST on the second beat of a 4-beat burst
      req_valid = 2'b01;
      req_len[0 +: 8] = 8'd3;
      settle();
      chk("t4b_req_ready", req_ready, 2'b01);
      cyc();
      req_valid = 2'b00;
      cyc();
      set_r(1'b1, 4'd0, 64'h50, 1'b0, 2'b01);
      settle();
      chk("t4b_resp_pass", rsp_resp, 2'b01);
      chk("t4b_last0", rsp_last, 1'b0);
      cyc();
      set_r(1'b1, 4'd0, 64'h51, 1'b1, 2'b00);
      settle();
      chk("t4b_resp_early", rsp_resp, 2'b10);
      chk("t4b_last1", rsp_last, 1'b0);
      chk("t4b_state_data", dbg_state, 2'd2);
      cyc();
      set_r(1'b0, 4'd0, 64'd0, 1'b0, 2'b00);
      settle();
      chk("t4b_state_idle", dbg_state, 2'd0);
      chk("t4b_rsp_valid_idle", rsp_valid, 2'b00);

      // 5: reset during beat 2 of 4, then a port 1 request
      req_valid = 2'b01;
      cyc();
      req_valid = 2'b00;
      cyc();
      set_r(1'b1, 4'd0, 64'h60, 1'b0, 2'b00);
      cyc();
      set_r(1'b1, 4'd0, 64'h61, 1'b0, 2'b00);
      cyc();
      set_r(1'b1, 4'd0, 64'h62, 1'b0, 2'b00);
      settle();
      chk("t5_beat2_valid", rsp_valid, 2'b01);
      rst = 1'b1;
      #1;
      chk("t5_rst_arvalid", arvalid, 1'b0);
      chk("t5_rst_rready", rready, 1'b0);
      chk("t5_rst_rsp_valid", rsp_valid, 2'b00);
      chk("t5_rst_state", dbg_state, 2'd0);
      cyc();
      cyc();
      rst = 1'b0;
      settle();
      chk("t5_late_rready", rready, 1'b0);
      chk("t5_late_rsp_valid", rsp_valid, 2'b00);
      req_valid = 2'b10;
      req_addr[64 +: 64] = 64'h7000;
      req_len[8 +: 8] = 8'd0;
      settle();
      chk("t5_req_ready", req_ready, 2'b10);
      cyc();
      req_valid = 2'b00;
      set_r(1'b1, 4'd1, 64'h77, 1'b1, 2'b00);
      rsp_ready = 2'b10;
      settle();
      chk("t5_arid", arid, 4'd1);
      chk("t5_araddr", araddr, 64'h7000);
      cyc();
      settle();
      chk("t5_rsp_valid", rsp_valid, 2'b10);
      chk("t5_rsp_resp", rsp_resp, 2'b00);
      cyc();
      set_r(1'b0, 4'd0, 64'd0, 1'b0, 2'b00);

      // 6: four ports requesting, instruction mask 0101
      for (int p = 0; p < 4; p++) begin
         req_addr_4[p*64 +: 64] = 64'h100 * 64'(p + 1);
      end
      req_valid_4 = 4'hF;
      arready_4 = 1'b1;
      rsp_ready_4 = 4'hF;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("t6_req_ready", req_ready_4, 4'b0001 << gnt4_t[i]);
         cyc();
         set_r4(1'b1, 4'(gnt4_t[i]), 64'h600 + 64'(i));
         settle();
         chk("t6_arid", arid_4, 4'(gnt4_t[i]));
         chk("t6_arport", arport_4, ap4_t[i]);
         chk("t6_araddr", araddr_4, 64'h100 * 64'(gnt4_t[i] + 1));
         cyc();
         settle();
         chk("t6_rsp_valid", rsp_valid_4, 4'b0001 << gnt4_t[i]);
         chk("t6_rsp_resp", rsp_resp_4, 2'b00);
         cyc();
         set_r4(1'b0, 4'd0, 64'd0);
      end
      req_valid_4 = 4'h0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
